// File: rtl/goe_arb.sv
// goe_arb: two-source store-and-forward packet arbiter feeding goe.
// Round-robin per packet; packets flagged invalid are drained silently.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data_wr_i/in_data_i      source i word strobe and 134b FAST word
//                               ([133:132] 01 head, 11 body, 10 tail)
//   in_valid_wr_i/in_valid_i    source i packet flag, same cycle as tail
//   out_alf_i             source i almost-full (registered)
//   out_goe_data_wr/out_goe_data      word stream to goe
//   out_goe_valid_wr/out_goe_valid    packet flag to goe, with tail word
//   out_err               sticky per-source overflow
//   out_pkt_cnt_0/1       packets forwarded per source (wrapping)
module goe_arb #(
    parameter int DATA_AW    = 8,
    parameter int PKT_AW     = 4,
    parameter int ALF_MARGIN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_data_wr_0,
    input  logic [133:0] in_data_0,
    input  logic         in_valid_wr_0,
    input  logic         in_valid_0,
    output logic         out_alf_0,
    input  logic         in_data_wr_1,
    input  logic [133:0] in_data_1,
    input  logic         in_valid_wr_1,
    input  logic         in_valid_1,
    output logic         out_alf_1,
    output logic         out_goe_data_wr,
    output logic [133:0] out_goe_data,
    output logic         out_goe_valid_wr,
    output logic         out_goe_valid,
    output logic [1:0]   out_err,
    output logic [15:0]  out_pkt_cnt_0,
    output logic [15:0]  out_pkt_cnt_1
);

    localparam int DDEPTH = 1 << DATA_AW;
    localparam int FDEPTH = 1 << PKT_AW;
    localparam logic [DATA_AW:0] DFULL = (DATA_AW+1)'(DDEPTH);
    localparam logic [DATA_AW:0] DMARG = (DATA_AW+1)'(ALF_MARGIN);
    localparam logic [PKT_AW:0]  FFULL = (PKT_AW+1)'(FDEPTH);
    localparam logic [PKT_AW:0]  FALF  = (PKT_AW+1)'(FDEPTH - 2);

    typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

    logic [1:0]         s_wr;
    logic [1:0]         s_vwr;
    logic [1:0]         s_v;
    logic [1:0][133:0]  s_din;

    assign s_wr  = {in_data_wr_1, in_data_wr_0};
    assign s_vwr = {in_valid_wr_1, in_valid_wr_0};
    assign s_v   = {in_valid_1, in_valid_0};
    assign s_din = {in_data_1, in_data_0};

    logic [133:0] dhead [2];
    logic [1:0]   dne;
    logic [1:0]   fne;
    logic [1:0]   fhead;
    logic [1:0]   dpop;
    logic [1:0]   fpop;
    logic [1:0]   alf_v;
    logic [1:0]   err_v;

    for (genvar i = 0; i < 2; i++) begin : g_src
        logic [133:0]     mem [DDEPTH];
        logic             fmem [FDEPTH];
        logic [DATA_AW:0] wp;
        logic [DATA_AW:0] rp;
        logic [DATA_AW:0] dcnt;
        logic [PKT_AW:0]  fwp;
        logic [PKT_AW:0]  frp;
        logic [PKT_AW:0]  fcnt;
        logic             in_pkt;
        logic             is_head;
        logic             is_tail;
        logic             acc;
        logic             dfull;
        logic             dwe;
        logic             ffull;
        logic             freq;
        logic             fwe;
        logic             err_r;
        logic             alf_r;

        assign is_head = s_din[i][133:132] == 2'b01;
        assign is_tail = s_din[i][133:132] == 2'b10;
        // Words outside a packet are dropped until the next head.
        assign acc     = s_wr[i] & (is_head | in_pkt);
        assign dcnt    = wp - rp;
        assign dfull   = dcnt == DFULL;
        assign dwe     = acc & ~dfull;
        assign fcnt    = fwp - frp;
        assign ffull   = fcnt == FFULL;
        // A flag is only queued when its tail was stored, so a flag
        // entry always implies a complete packet in the data FIFO.
        assign freq    = s_vwr[i] & acc & is_tail & ~dfull;
        assign fwe     = freq & ~ffull;

        always_ff @(posedge clk) begin
            if (dwe)
                mem[wp[DATA_AW-1:0]] <= s_din[i];
            if (fwe)
                fmem[fwp[PKT_AW-1:0]] <= s_v[i];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp     <= '0;
                rp     <= '0;
                fwp    <= '0;
                frp    <= '0;
                in_pkt <= 1'b0;
                err_r  <= 1'b0;
                alf_r  <= 1'b0;
            end else begin
                wp  <= wp + (DATA_AW+1)'(dwe);
                rp  <= rp + (DATA_AW+1)'(dpop[i]);
                fwp <= fwp + (PKT_AW+1)'(fwe);
                frp <= frp + (PKT_AW+1)'(fpop[i]);
                if (acc & is_head)
                    in_pkt <= 1'b1;
                else if (acc & is_tail)
                    in_pkt <= 1'b0;
                if ((acc & dfull) | (freq & ffull))
                    err_r <= 1'b1;
                alf_r <= ((DFULL - dcnt) < DMARG) | (fcnt >= FALF);
            end
        end

        assign dhead[i] = mem[rp[DATA_AW-1:0]];
        assign fhead[i] = fmem[frp[PKT_AW-1:0]];
        assign dne[i]   = dcnt != '0;
        assign fne[i]   = fcnt != '0;
        assign alf_v[i] = alf_r;
        assign err_v[i] = err_r;
    end

    assign out_alf_0 = alf_v[0];
    assign out_alf_1 = alf_v[1];
    assign out_err   = err_v;

    state_t       state;
    logic         gsel;
    logic         rr_last;
    logic         gv;
    logic         gnt;
    logic [133:0] cur;
    logic         cur_tail;

    assign gv       = |fne;
    // With both ready, the source that did not win last time goes.
    assign gnt      = (&fne) ? ~rr_last : fne[1];
    assign cur      = dhead[gsel];
    assign cur_tail = cur[133:132] == 2'b10;

    always_comb begin
        fpop = '0;
        dpop = '0;
        unique case (state)
            IDLE:      if (gv) fpop[gnt] = 1'b1;
            SEND, DROP: dpop[gsel] = dne[gsel];
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            gsel             <= 1'b0;
            rr_last          <= 1'b1;
            out_goe_data_wr  <= 1'b0;
            out_goe_data     <= '0;
            out_goe_valid_wr <= 1'b0;
            out_goe_valid    <= 1'b0;
            out_pkt_cnt_0    <= '0;
            out_pkt_cnt_1    <= '0;
        end else begin
            out_goe_data_wr  <= 1'b0;
            out_goe_data     <= '0;
            out_goe_valid_wr <= 1'b0;
            out_goe_valid    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gv) begin
                        gsel    <= gnt;
                        rr_last <= gnt;
                        state   <= fhead[gnt] ? SEND : DROP;
                    end
                end
                SEND: begin
                    if (dpop[gsel]) begin
                        out_goe_data_wr <= 1'b1;
                        out_goe_data    <= cur;
                        if (cur_tail) begin
                            out_goe_valid_wr <= 1'b1;
                            out_goe_valid    <= 1'b1;
                            if (gsel)
                                out_pkt_cnt_1 <= out_pkt_cnt_1 + 16'd1;
                            else
                                out_pkt_cnt_0 <= out_pkt_cnt_0 + 16'd1;
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (dpop[gsel] & cur_tail)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
